// File: rtl/fuzz_mem_responder.sv
// rtl/fuzz_mem_responder.sv - memory responder with core reset sequencer; optional write trap via FUZZ_MEM_TRAP_EN
module fuzz_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned RST_CYCLES  = 15,
    parameter logic [31:0] TRAP_ADDR   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        core_resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] fetch_count,
    output logic [31:0] write_count,
    output logic        oob_err,
    output logic        trap
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    rst_cnt;
    logic [3:0]    wait_cnt;
    logic [29:0]   cap_word;
    logic [31:0]   cap_wdata;
    logic [3:0]    cap_wstrb;
    logic          cap_instr;
    logic          cap_write;
    logic          cap_oob;
    logic [AW-1:0] cap_idx;
    logic          accept;
    logic          blocked;
    logic          unused_addr_lsb;

    // Contents are preloaded externally and deliberately survive rst.
    logic [31:0]   mem [DEPTH_WORDS];

    assign unused_addr_lsb = ^mem_addr[1:0];
    assign cap_write       = (cap_wstrb != 4'd0);
    assign cap_oob         = (cap_word >= 30'(DEPTH_WORDS));
    assign cap_idx         = cap_word[AW-1:0];
    assign accept          = (state == S_IDLE) && mem_valid && core_resetn && !blocked;
    assign core_resetn     = (rst_cnt == 8'(RST_CYCLES));

    // Hold the core in reset for RST_CYCLES clocks after rst, then saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rst_cnt <= 8'd0;
        else if (rst_cnt < 8'(RST_CYCLES))
            rst_cnt <= rst_cnt + 8'd1;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: WAIT aborts as soon as the core drops mem_valid.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT: begin
                if (!mem_valid)
                    state_nxt = S_IDLE;
                else if (wait_cnt == 4'd1)
                    state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: single-cycle ready pulse, read data only for in-range reads.
    always_comb begin
        mem_ready = (state == S_RESP);
        mem_rdata = 32'd0;
        if (state == S_RESP && !cap_write && !cap_oob)
            mem_rdata = mem[cap_idx];
    end

    // Request capture at accept so later input wiggles cannot disturb the transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= 4'd0;
            cap_word  <= 30'd0;
            cap_wdata <= 32'd0;
            cap_wstrb <= 4'd0;
            cap_instr <= 1'b0;
        end else if (accept) begin
            wait_cnt  <= 4'(WAIT_STATES);
            cap_word  <= mem_addr[31:2];
            cap_wdata <= mem_wdata;
            cap_wstrb <= mem_wstrb;
            cap_instr <= mem_instr;
        end else if (state == S_WAIT) begin
            wait_cnt  <= wait_cnt - 4'd1;
        end
    end

    // Byte-lane write commits only in RESP, so a reset or abort never leaves a partial write.
    always_ff @(posedge clk) begin
        if (!rst && state == S_RESP && cap_write && !cap_oob) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_wstrb[i])
                    mem[cap_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
            end
        end
    end

    // Completion counters and sticky out-of-range flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= 32'd0;
            write_count <= 32'd0;
            oob_err     <= 1'b0;
        end else if (state == S_RESP) begin
            if (cap_write)
                write_count <= write_count + 32'd1;
            else if (cap_instr)
                fetch_count <= fetch_count + 32'd1;
            if (cap_oob)
                oob_err <= 1'b1;
        end
    end

`ifdef FUZZ_MEM_TRAP_EN
    logic trap_q;

    // Sticky trap on a completed write to the monitored word; it also freezes the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            trap_q <= 1'b0;
        else if (state == S_RESP && cap_write && cap_word == TRAP_ADDR[31:2])
            trap_q <= 1'b1;
    end

    assign trap    = trap_q;
    assign blocked = trap_q;
`else
    logic unused_trap_addr;

    assign unused_trap_addr = ^TRAP_ADDR;
    assign trap             = 1'b0;
    assign blocked          = 1'b0;
`endif

endmodule

// File: tb/tb_fuzz_mem_responder.sv
// tb/tb_fuzz_mem_responder.sv - self-checking bench for fuzz_mem_responder
module tb_fuzz_mem_responder;

    localparam int          DEPTH = 16;
    localparam int          WS    = 2;
    localparam int          RC    = 15;
    localparam logic [31:0] TRAP  = 32'h0000_0030;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_resetn;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr  = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [3:0]  mem_wstrb = 4'd0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] fetch_count;
    logic [31:0] write_count;
    logic        oob_err;
    logic        trap;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] fetch_m = 32'd0;
    logic [31:0] write_m = 32'd0;
    logic        oob_m   = 1'b0;

    fuzz_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WS),
        .RST_CYCLES  (RC),
        .TRAP_ADDR   (TRAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core_resetn (core_resetn),
        .mem_valid   (mem_valid),
        .mem_instr   (mem_instr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .fetch_count (fetch_count),
        .write_count (write_count),
        .oob_err     (oob_err),
        .trap        (trap)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference behaviour of one completed transaction.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic ins, output logic [31:0] exp_rd);
        int unsigned idx;
        bit          oob;
        idx    = a[31:2];
        oob    = (idx >= DEPTH);
        exp_rd = 32'd0;
        if (oob)
            oob_m = 1'b1;
        if (s != 4'd0) begin
            write_m++;
            if (!oob)
                for (int i = 0; i < 4; i++)
                    if (s[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
        end else begin
            if (ins)
                fetch_m++;
            if (!oob)
                exp_rd = mem_m[idx];
        end
    endtask

    // Called at posedge+1 with the FSM idle; returns at posedge+1 with the FSM idle.
    task automatic run(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic ins, output logic [31:0] rd);
        logic [31:0] exp_rd;
        int          lat;
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_instr = ins;
        lat       = -1;
        rd        = 32'hxxxx_xxxx;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                lat = n;
                rd  = mem_rdata;
                break;
            end
            @(posedge clk);
            #1;
            if (n == 0) begin
                mem_addr  = $urandom;
                mem_wdata = $urandom;
                mem_wstrb = 4'($urandom);
                mem_instr = 1'($urandom);
            end
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        model(a, d, s, ins, exp_rd);
        chk("rdata", rd, exp_rd);
        chk("latency", 32'(lat), 32'(WS + 1));
        @(negedge clk);
        chk("ready_one_cycle", {31'd0, mem_ready}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_core(input string tag);
        int k;
        k = 0;
        while (core_resetn !== 1'b1 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, {31'd0, core_resetn}, 32'd1);
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_fetch"}, fetch_count, fetch_m);
        chk({tag, "_write"}, write_count, write_m);
        chk({tag, "_oob"}, {31'd0, oob_err}, {31'd0, oob_m});
    endtask

    initial begin : main
        logic [31:0] rd;
        logic [31:0] d;
        logic [31:0] a;
        logic [3:0]  s;
        bit          seen;

        #12;
        chk("rst_core_resetn", {31'd0, core_resetn}, 32'd0);
        chk("rst_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk_status("rst");

        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("core_resetn_seq", {31'd0, core_resetn}, {31'd0, (k >= RC)});
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            if (i == 4) d = 32'hDEAD_BEEF;
            if (i == 8) d = 32'h1122_3344;
            run(32'(i * 4), d, 4'hF, 1'b0, rd);
        end
        chk_status("preload");

        rst = 1'b1;
        #1;
        chk_status_zero: begin
            chk("pulse_fetch", fetch_count, 32'd0);
            chk("pulse_write", write_count, 32'd0);
        end
        fetch_m = 32'd0;
        write_m = 32'd0;
        oob_m   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_core("core_resetn_after_pulse");

        run(32'h20, 32'hAABB_CCDD, 4'b0010, 1'b0, rd);
        chk("lane_write_count", write_count, 32'd1);
        run(32'h20, 32'h0, 4'b0000, 1'b0, rd);
        chk("lane_merge", rd, 32'h1122_CC44);

        run(32'h10, 32'h0, 4'b0000, 1'b1, rd);
        chk("deadbeef", rd, 32'hDEAD_BEEF);
        chk("fetch_one", fetch_count, 32'd1);

        run(32'h40, 32'h0, 4'b0000, 1'b0, rd);
        chk("oob_rdata", rd, 32'd0);
        chk("oob_flag", {31'd0, oob_err}, 32'd1);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0)
                a = $urandom;
            else
                a = (32'($urandom_range(0, 19)) << 2) | 32'($urandom_range(0, 3));
            s = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            run(a, $urandom, s, 1'($urandom), rd);
        end
        chk_status("random");

        mem_valid = 1'b1;
        mem_addr  = 32'h8;
        mem_wdata = ~mem_m[2];
        mem_wstrb = 4'hF;
        mem_instr = 1'b0;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) seen = 1'b1;
        end
        chk("abort_no_ready", {31'd0, seen}, 32'd0);
        @(posedge clk);
        #1;
        chk_status("abort");
        run(32'h8, 32'h0, 4'b0000, 1'b0, rd);

        mem_valid = 1'b1;
        mem_addr  = 32'h14;
        mem_wdata = ~mem_m[5];
        mem_wstrb = 4'hF;
        mem_instr = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_valid = 1'b0;
        #1;
        fetch_m = 32'd0;
        write_m = 32'd0;
        oob_m   = 1'b0;
        chk("midrst_core_resetn", {31'd0, core_resetn}, 32'd0);
        chk("midrst_ready", {31'd0, mem_ready}, 32'd0);
        chk("midrst_rdata", mem_rdata, 32'd0);
        chk("midrst_trap", {31'd0, trap}, 32'd0);
        chk_status("midrst");
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) seen = 1'b1;
        end
        chk("midrst_no_ready", {31'd0, seen}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_core("core_resetn_after_midrst");
        run(32'h14, 32'h0, 4'b0000, 1'b0, rd);

`ifdef FUZZ_MEM_TRAP_EN
        run(TRAP, $urandom, 4'hF, 1'b0, rd);
        chk("trap_set", {31'd0, trap}, 32'd1);
        mem_valid = 1'b1;
        mem_addr  = 32'h0;
        mem_wstrb = 4'd0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) seen = 1'b1;
        end
        mem_valid = 1'b0;
        chk("trap_blocks", {31'd0, seen}, 32'd0);
`else
        run(TRAP, $urandom, 4'hF, 1'b0, rd);
        chk("trap_tied_low", {31'd0, trap}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
